perceptron_train_ctrl: RTL and testbench
========================================

# perceptron_train_ctrl

Sequencing and training controller for the on-chip perceptron datapath. It accepts labelled 8-feature binary samples over a valid/ready handshake and runs a time-multiplexed accumulate: one weight per cycle through a single shared adder. It returns the classification and, in training mode, applies the perceptron learning rule with saturating weight updates. It sits between the tile's input switches/host interface and the classification output, and owns the weight and bias storage.

## Interface
- `N_FEAT`, 8: number of binary features; also the weight count.
- `W_W`, 6: signed weight/bias width in bits.
- `THRESH`, 0: signed decision threshold; class = 1 when acc >= THRESH.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset; asynchronous, active-low.
- `in_valid`  in  1: sample offered.
- `in_ready`  out  1: controller can accept (IDLE and no `clear_weights`).
- `in_x`  in  N_FEAT: feature bits.
- `in_label`  in  1: target class (used in training only).
- `in_train`  in  1: 1 = training sample, 0 = inference only.
- `out_valid`  out  1: result available.
- `out_ready`  in  1: result consumed.
- `out_class`  out  1: decided class.
- `out_error`  out  1: training sample misclassified (0 for inference).
- `clear_weights`  in  1: zero all weights, bias and `err_count`.
- `busy`  out  1: state is not IDLE.
- `err_count`  out  8: saturating count of training errors.
- `w_sel`  in  clog2(N_FEAT)+1: readout select; N_FEAT selects bias.
- `w_rd`  out  W_W: combinational weight/bias readout.

## Operation
- States: IDLE, ACCUM, DECIDE, UPDATE, RESP.
- IDLE:
  - `in_ready`=1 unless `clear_weights`=1.
  - Accept when `in_valid && in_ready`: latch x, label, train; set acc = sign-extended bias; go to ACCUM.
- ACCUM: index i counts 0..N_FEAT-1, one per cycle.
  - If x[i]: acc += w[i].
  - After i = N_FEAT-1, go to DECIDE.
- DECIDE (1 cycle):
  - class = (acc >= THRESH).
  - error = train && (class != label).
  - error → UPDATE; otherwise → RESP.
- UPDATE: N_FEAT cycles, i = 0..N_FEAT-1.
  - If x[i]: w[i] += (label ? +1 : -1).
  - Bias is updated the same way in the cycle where i=0.
  - `err_count` increments in that i=0 cycle, saturating at 255.
  - All weight arithmetic saturates at [-2^(W_W-1), 2^(W_W-1)-1]; it never wraps.
  - Then → RESP.
- RESP:
  - `out_valid`=1; `out_class`/`out_error` are held stable.
  - On `out_ready` → IDLE.
- Accumulator width is ACC_W = W_W + clog2(N_FEAT+1), signed. It cannot overflow: 9 terms × 6 b needs 10 b.
- `clear_weights` is honoured only in IDLE and wins over a simultaneous `in_valid`: no accept that cycle. In other states it is ignored.
- `in_*` are ignored outside IDLE.
- Reset values: state IDLE, all weights/bias 0, acc 0, i 0, `err_count` 0, `out_valid` 0, `out_class` 0, `out_error` 0, `busy` 0, `in_ready` 1.
- Reset mid-operation aborts the sample and clears learned weights. No partial result is emitted.

## Timing
- Accepting edge = edge 0.
- No update: `out_valid` rises after edge N_FEAT+1 (edge 9 at default).
- With update: `out_valid` rises after edge 2·N_FEAT+1 (edge 17).
- The RESP→IDLE transition happens at the edge where `out_ready`=1. `in_ready` is high the following cycle, so there is at most one sample in flight and no back-to-back accept in RESP.
- `out_valid` may stay high indefinitely; outputs do not change while it waits.
- `w_rd` reflects updates the cycle after the writing edge.

## Structure
- `perceptron_pkg` holds:
  - the state enum;
  - default N_FEAT/W_W constants;
  - a `sat_step` function (signed ±1 with clamp);
  - the ACC_W derivation.
- One sub-module, `perceptron_weight_bank`:
  - N_FEAT+1 signed registers with async clear on reset and sync clear input;
  - one indexed saturating ±1 write port;
  - combinational read ports: the sequencer index and `w_sel`.
- The FSM, index counter and accumulator live in the top.

## Test plan
- After reset, `in_x`=0x00, `in_train`=0 → `out_valid` after edge 9, `out_class`=1 (acc 0 ≥ 0), `out_error`=0, `err_count`=0.
- From reset, train `in_x`=0x0F, `in_label`=0:
  - → `out_class`=1, `out_error`=1, `out_valid` after edge 17;
  - then w[0..3]=-1, bias=-1, w[4..7]=0, `err_count`=1.
  - Repeat the same sample → acc=-5, `out_class`=0, `out_error`=0, latency 9.
- Saturation: train `in_x`=0x01, `in_label`=1 with THRESH=100, 40 times → w[0] and bias stop at +31, never wrap; `err_count`=40.
- Backpressure: hold `out_ready`=0 for 5 cycles in RESP → `out_valid`/`out_class` stable, `in_ready`=0; release → `in_ready`=1 next cycle.
- `clear_weights` and `in_valid` high together in IDLE → no accept, all `w_rd` = 0, `err_count`=0.
- Assert `rst_n`=0 during ACCUM (i=3) → immediately IDLE, `out_valid`=0, weights 0, `in_ready`=1.

Source files
------------

// File: rtl/perceptron_pkg.sv
// rtl/perceptron_pkg.sv - shared types, defaults and arithmetic helpers for the perceptron controller
package perceptron_pkg;

    localparam int N_FEAT_DEF = 8;
    localparam int W_W_DEF    = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_DECIDE,
        ST_UPDATE,
        ST_RESP
    } state_e;

    // Widest sum is N_FEAT weights plus the bias, so one extra bit per doubling of terms.
    function automatic int acc_width(input int w_w, input int n_feat);
        return w_w + $clog2(n_feat + 1);
    endfunction

    function automatic int sat_step(input int val, input logic up, input int w_w);
        int hi;
        int lo;
        hi = (1 << (w_w - 1)) - 1;
        lo = -(1 << (w_w - 1));
        if (up) begin
            return (val >= hi) ? hi : val + 1;
        end
        return (val <= lo) ? lo : val - 1;
    endfunction

endpackage

// File: rtl/perceptron_weight_bank.sv
// rtl/perceptron_weight_bank.sv - weight and bias registers with saturating +/-1 update port
module perceptron_weight_bank
    import perceptron_pkg::*;
#(
    parameter int N_FEAT = N_FEAT_DEF,
    parameter int W_W    = W_W_DEF,
    parameter int IDX_W  = $clog2(N_FEAT),
    parameter int SEL_W  = $clog2(N_FEAT) + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr_i,
    input  logic                    upd_w_i,
    input  logic                    upd_b_i,
    input  logic                    up_i,
    input  logic [IDX_W-1:0]        idx_i,
    input  logic [SEL_W-1:0]        sel_i,
    output logic signed [W_W-1:0]   w_idx_o,
    output logic signed [W_W-1:0]   bias_o,
    output logic signed [W_W-1:0]   w_sel_o
);

    localparam logic [SEL_W-1:0] BIAS_IX = SEL_W'(N_FEAT);

    // Entry N_FEAT holds the bias so the readout select can reach it directly.
    logic signed [W_W-1:0] w_q [N_FEAT+1];
    logic [SEL_W-1:0]      idx_ext;

    assign idx_ext = SEL_W'(idx_i);
    assign w_idx_o = w_q[idx_ext];
    assign bias_o  = w_q[BIAS_IX];
    assign w_sel_o = (sel_i <= BIAS_IX) ? w_q[sel_i] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= N_FEAT; k++) begin
                w_q[k] <= '0;
            end
        end else if (clr_i) begin
            for (int k = 0; k <= N_FEAT; k++) begin
                w_q[k] <= '0;
            end
        end else begin
            if (upd_w_i) begin
                w_q[idx_ext] <= W_W'(sat_step(int'(w_q[idx_ext]), up_i, W_W));
            end
            if (upd_b_i) begin
                w_q[BIAS_IX] <= W_W'(sat_step(int'(w_q[BIAS_IX]), up_i, W_W));
            end
        end
    end

endmodule

// File: rtl/perceptron_train_ctrl.sv
// rtl/perceptron_train_ctrl.sv - sequencer running serial accumulate, decision and perceptron update
module perceptron_train_ctrl
    import perceptron_pkg::*;
#(
    parameter int N_FEAT = N_FEAT_DEF,
    parameter int W_W    = W_W_DEF,
    parameter int THRESH = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N_FEAT-1:0]          in_x,
    input  logic                       in_label,
    input  logic                       in_train,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_class,
    output logic                       out_error,
    input  logic                       clear_weights,
    output logic                       busy,
    output logic [7:0]                 err_count,
    input  logic [$clog2(N_FEAT):0]    w_sel,
    output logic [W_W-1:0]             w_rd
);

    localparam int ACC_W = acc_width(W_W, N_FEAT);
    localparam int IDX_W = $clog2(N_FEAT);
    localparam int SEL_W = $clog2(N_FEAT) + 1;
    localparam logic signed [ACC_W-1:0] THR  = ACC_W'(THRESH);
    localparam logic [IDX_W-1:0]        LAST = IDX_W'(N_FEAT - 1);

    state_e                   state_q;
    logic [N_FEAT-1:0]        x_q;
    logic                     label_q;
    logic                     train_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  acc_d;
    logic [IDX_W-1:0]         idx_q;
    logic [7:0]               err_cnt_q;
    logic                     out_valid_q;
    logic                     out_class_q;
    logic                     out_error_q;

    logic                     accept;
    logic                     clr;
    logic                     upd_w;
    logic                     upd_b;
    logic                     cls_d;
    logic                     err_d;
    logic signed [W_W-1:0]    w_cur;
    logic signed [W_W-1:0]    bias;
    logic signed [W_W-1:0]    w_sel_val;

    perceptron_weight_bank #(
        .N_FEAT (N_FEAT),
        .W_W    (W_W),
        .IDX_W  (IDX_W),
        .SEL_W  (SEL_W)
    ) u_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (clr),
        .upd_w_i (upd_w),
        .upd_b_i (upd_b),
        .up_i    (label_q),
        .idx_i   (idx_q),
        .sel_i   (w_sel),
        .w_idx_o (w_cur),
        .bias_o  (bias),
        .w_sel_o (w_sel_val)
    );

    // clear_weights takes priority over an offered sample in the same cycle.
    always_comb begin
        accept = (state_q == ST_IDLE) && in_valid && !clear_weights;
        clr    = (state_q == ST_IDLE) && clear_weights;
        upd_w  = (state_q == ST_UPDATE) && x_q[idx_q];
        upd_b  = (state_q == ST_UPDATE) && (idx_q == '0);
        acc_d  = acc_q;
        if (x_q[idx_q]) begin
            acc_d = acc_q + ACC_W'(w_cur);
        end
        cls_d  = (acc_q >= THR);
        err_d  = train_q && (cls_d != label_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            x_q         <= '0;
            label_q     <= 1'b0;
            train_q     <= 1'b0;
            acc_q       <= '0;
            idx_q       <= '0;
            err_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_class_q <= 1'b0;
            out_error_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (clr) begin
                        err_cnt_q <= '0;
                    end else if (accept) begin
                        x_q     <= in_x;
                        label_q <= in_label;
                        train_q <= in_train;
                        acc_q   <= ACC_W'(bias);
                        idx_q   <= '0;
                        state_q <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    acc_q <= acc_d;
                    if (idx_q == LAST) begin
                        idx_q   <= '0;
                        state_q <= ST_DECIDE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                ST_DECIDE: begin
                    out_class_q <= cls_d;
                    out_error_q <= err_d;
                    out_valid_q <= !err_d;
                    state_q     <= err_d ? ST_UPDATE : ST_RESP;
                end
                ST_UPDATE: begin
                    if ((idx_q == '0) && (err_cnt_q != 8'hFF)) begin
                        err_cnt_q <= err_cnt_q + 8'd1;
                    end
                    if (idx_q == LAST) begin
                        idx_q       <= '0;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_RESP;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == ST_IDLE) && !clear_weights;
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = out_valid_q;
    assign out_class = out_class_q;
    assign out_error = out_error_q;
    assign err_count = err_cnt_q;
    assign w_rd      = w_sel_val;

endmodule

// File: tb/tb_perceptron_train_ctrl.sv
// tb/tb_perceptron_train_ctrl.sv - directed self-checking bench for perceptron_train_ctrl
module tb_perceptron_train_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_x;
    logic       in_label;
    logic       in_train;
    logic       out_ready;
    logic       clear_weights;
    logic [3:0] w_sel;
    logic       sel_s;

    logic       a_in_ready, a_out_valid, a_out_class, a_out_error, a_busy;
    logic [7:0] a_err_count;
    logic [5:0] a_w_rd;
    logic       b_in_ready, b_out_valid, b_out_class, b_out_error, b_busy;
    logic [7:0] b_err_count;
    logic [5:0] b_w_rd;

    logic       in_ready, out_valid, out_class, out_error, busy;
    logic [7:0] err_count;
    logic [5:0] w_rd;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    perceptron_train_ctrl #(.N_FEAT(8), .W_W(6), .THRESH(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid & ~sel_s), .in_ready(a_in_ready),
        .in_x(in_x), .in_label(in_label), .in_train(in_train),
        .out_valid(a_out_valid), .out_ready(out_ready & ~sel_s), .out_class(a_out_class),
        .out_error(a_out_error), .clear_weights(clear_weights), .busy(a_busy),
        .err_count(a_err_count), .w_sel(w_sel), .w_rd(a_w_rd)
    );

    perceptron_train_ctrl #(.N_FEAT(8), .W_W(6), .THRESH(100)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid & sel_s), .in_ready(b_in_ready),
        .in_x(in_x), .in_label(in_label), .in_train(in_train),
        .out_valid(b_out_valid), .out_ready(out_ready & sel_s), .out_class(b_out_class),
        .out_error(b_out_error), .clear_weights(clear_weights), .busy(b_busy),
        .err_count(b_err_count), .w_sel(w_sel), .w_rd(b_w_rd)
    );

    assign in_ready  = sel_s ? b_in_ready  : a_in_ready;
    assign out_valid = sel_s ? b_out_valid : a_out_valid;
    assign out_class = sel_s ? b_out_class : a_out_class;
    assign out_error = sel_s ? b_out_error : a_out_error;
    assign busy      = sel_s ? b_busy      : a_busy;
    assign err_count = sel_s ? b_err_count : a_err_count;
    assign w_rd      = sel_s ? b_w_rd      : a_w_rd;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic rdw(input int s, output logic signed [31:0] v);
        w_sel = 4'(s);
        #1;
        v = $signed(w_rd);
    endtask

    task automatic run(input logic [7:0] x, input logic lbl, input logic trn,
                       input int exp_lat, input logic exp_cls, input logic exp_err, input string tag);
        int n;
        int lat;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        in_x = x; in_label = lbl; in_train = trn; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; in_x = ~x; in_label = ~lbl;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_class"}, out_class, exp_cls);
        chk({tag, "_error"}, out_error, exp_err);
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_in_ready_after"}, in_ready, 1);
        chk({tag, "_out_valid_after"}, out_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic signed [31:0] v;
        rst_n = 1'b0; in_valid = 1'b0; in_x = '0; in_label = 1'b0; in_train = 1'b0;
        out_ready = 1'b0; clear_weights = 1'b0; w_sel = '0; sel_s = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_class", out_class, 0);
        chk("rst_error", out_error, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_err_count", err_count, 0);
        rdw(8, v); chk("rst_bias", v, 0);

        // inference of an all-zero sample: acc = 0 >= 0
        run(8'h00, 1'b0, 1'b0, 9, 1'b1, 1'b0, "inf0");
        chk("inf0_err_count", err_count, 0);
        consume("inf0");

        // training miss: class 1 vs label 0, decrement active weights and bias
        run(8'h0F, 1'b0, 1'b1, 17, 1'b1, 1'b1, "train1");
        consume("train1");
        for (int s = 0; s < 4; s++) begin
            rdw(s, v); chk("train1_w_low", v, -1);
        end
        rdw(4, v); chk("train1_w4", v, 0);
        rdw(7, v); chk("train1_w7", v, 0);
        rdw(8, v); chk("train1_bias", v, -1);
        chk("train1_err_count", err_count, 1);

        // same sample again: acc = -1 - 4 = -5, now correct
        run(8'h0F, 1'b0, 1'b1, 9, 1'b0, 1'b0, "train2");
        chk("train2_err_count", err_count, 1);
        consume("train2");

        // backpressure in RESP: acc = bias -1, class 0
        run(8'hF0, 1'b0, 1'b0, 9, 1'b0, 1'b0, "bp");
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_out_valid_hold", out_valid, 1);
            chk("bp_class_hold", out_class, 0);
            chk("bp_in_ready_low", in_ready, 0);
        end
        consume("bp");

        // clear_weights wins over in_valid
        clear_weights = 1'b1; in_valid = 1'b1; in_x = 8'hFF; in_train = 1'b1; in_label = 1'b1;
        #1;
        chk("clr_in_ready_low", in_ready, 0);
        @(negedge clk);
        clear_weights = 1'b0; in_valid = 1'b0;
        chk("clr_no_accept", busy, 0);
        for (int s = 0; s <= 8; s++) begin
            rdw(s, v); chk("clr_w_zero", v, 0);
        end
        chk("clr_err_count", err_count, 0);

        // saturation on the THRESH=100 instance: every sample is a miss
        sel_s = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 40; k++) begin
            run(8'h01, 1'b1, 1'b1, 17, 1'b0, 1'b1, "sat");
            consume("sat");
            if (k == 30) begin
                rdw(0, v); chk("sat_w0_reach", v, 31);
            end
        end
        rdw(0, v); chk("sat_w0_final", v, 31);
        rdw(8, v); chk("sat_bias_final", v, 31);
        rdw(1, v); chk("sat_w1", v, 0);
        chk("sat_err_count", err_count, 40);
        sel_s = 1'b0;
        @(negedge clk);

        // reset during ACCUM at i=3
        run(8'h0F, 1'b0, 1'b1, 17, 1'b1, 1'b1, "retrain");
        consume("retrain");
        rdw(0, v); chk("retrain_w0", v, -1);
        in_x = 8'hFF; in_train = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("mid_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_busy", busy, 0);
        chk("mid_out_valid", out_valid, 0);
        chk("mid_in_ready", in_ready, 1);
        chk("mid_err_count", err_count, 0);
        rdw(0, v); chk("mid_w0", v, 0);
        rdw(8, v); chk("mid_bias", v, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run(8'h0F, 1'b0, 1'b0, 9, 1'b1, 1'b0, "post_rst");
        consume("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
